cpu_v2: RTL and testbench
=========================

CPU_V2 -- requirements
Module: cpu_v2

Interface
REQ-001 Parameters SHALL be:
- DWIDTH, default 16, datapath/register/data-bus width (legal 16..32).
- IADDRWIDTH, default 16, instruction address width.
- DADDRWIDTH, default 16, data address width.
- NREGS, default 8, register count (fixed 8; reserved for growth, other values SHALL fail elaboration).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iaddr  out  IADDRWIDTH  instruction fetch address (pc_next).
- idata  in  16  instruction word for iaddr, valid the following cycle.
- raddr  out  DADDRWIDTH  load address.
- re  out  1  load request.
- rdata  in  DWIDTH  load data, valid when rvalid=1.
- rvalid  in  1  load completion.
- waddr  out  DADDRWIDTH  store address.
- wdata  out  DWIDTH  store data.
- we  out  1  store request.
- wready  in  1  store accepted this cycle.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous, active-low reset, as decided.

Function
REQ-004 Two stages SHALL be used: S1 fetch (pc, iaddr=pc_next); S2 decode/execute (ir).
REQ-005 Encoding SHALL be 16-bit: op[15:12], d_ind[11], rd[10:8], ra[7:5], bmode[4:3], rb[2:0]; branch cc[13:10], off[9:0].
REQ-006 Immediates and rdata/registers SHALL be sign-extended to DWIDTH (4-bit imm) and IADDRWIDTH (10-bit branch offset); ALU results SHALL wrap modulo 2^DWIDTH; flags N,Z,C,V SHALL derive from the DWIDTH-bit result.
REQ-007 Branch op 10?? SHALL compute pc+off; on taken it SHALL redirect S1 and replace the delay slot with nop (0x0000).
REQ-008 Conditions SHALL be eq,ne,cs,cc,mi,pl,vs,vc,hi(C&!Z),ls(!C|Z),ge,lt,gt,le,nv,al for cc 0..15.
REQ-009 Op 11?? SHALL execute as nop with no state change.
REQ-010 Operand b modes SHALL be: 0? imm4; 10 rb!=0 register; 10 rb=0 next-word immediate (state IMM, one extra cycle); 11 rb=0 returns pc+1; 11 rb!=0 memory load.
REQ-011 The S2 FSM SHALL have states DECODE, IMM, LOAD, STORE. Transitions:
- Load: DECODE->LOAD with re=1.
- LOAD: hold re, raddr stable, stall S1 until rvalid=1; capture rdata; writeback rd in that same cycle; return to DECODE.
- rvalid while re=0 SHALL be ignored.
REQ-012 d_ind=1, rd!=0 SHALL store: we=1, waddr=reg[rd], wdata=result, S1 stalled, held stable in STORE until wready=1; completes the cycle wready=1; there SHALL be no register writeback; flags SHALL update once, on completion.
REQ-013 Load followed by indirect store in one instruction SHALL sequence LOAD then STORE; re and we SHALL never be asserted together.
REQ-014 d_ind=1, rd=0 SHALL jump to result, suppress flag update, and nop the delay slot.
REQ-015 Stall SHALL hold pc and ir; minimum load = 2 cycles (rvalid on first LOAD cycle); minimum store = 1 cycle (wready in DECODE).

Reset
REQ-016 While rst_n=0: pc = all-ones (first fetch address 0); ir=0; state=DECODE; flags=0; re=0; we=0; registers SHALL not be reset.
REQ-017 Reset mid-load or mid-store SHALL deassert re/we immediately (asynchronously); late rvalid/wready SHALL be ignored.

Structure
REQ-018 Package cpu_v2_pkg SHALL hold state_t, op/bmode/cc encodings, and the nop constant.
REQ-019 The register file (cpu_v2_regfile, parametrised DWIDTH, 3 read ports, 1 write port) and the ALU (cpu_v2_alu, parametrised DWIDTH) SHALL be sub-modules.

Verification
REQ-020 Scenarios a bench SHALL cover:
- DWIDTH=32: add r1 = r0 + imm -1 -> r1=0xFFFFFFFF, N=1, Z=0.
- Load with rvalid delayed 3 cycles -> re high 4 cycles, raddr stable, pc frozen, rd=rdata 0x1234.
- Store to [r2=0x40] with wready low 2 cycles -> we held 3 cycles, waddr=0x40, no register change.
- bhi with C=1,Z=0 -> taken, delay slot nop; with C=1,Z=1 -> not taken.
- rst_n low during LOAD -> re=0 same cycle; after release, first iaddr=0.

Source files
------------

// File: rtl/cpu_v2_pkg.sv
// Shared types and encodings for the cpu_v2 two-stage core.
// Used by the interface, datapath sub-modules and the top.
package cpu_v2_pkg;

  typedef enum logic [1:0] {
    S_DECODE = 2'd0,
    S_IMM    = 2'd1,
    S_LOAD   = 2'd2,
    S_STORE  = 2'd3
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // op 0000 is the nop encoding; 10?? is branch, 11?? is an explicit nop
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_ADC = 4'h7;

  localparam logic [1:0] BM_REG = 2'b10;
  localparam logic [1:0] BM_MEM = 2'b11;

  localparam logic [3:0] CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12, CC_LE = 4'd13, CC_NV = 4'd14, CC_AL = 4'd15;

  localparam logic [15:0] NOP_INSN = 16'h0000;

  function automatic logic cond_met(input logic [3:0] cc, input flags_t f);
    logic r;
    case (cc)
      CC_EQ:   r = f.z;
      CC_NE:   r = !f.z;
      CC_CS:   r = f.c;
      CC_CC:   r = !f.c;
      CC_MI:   r = f.n;
      CC_PL:   r = !f.n;
      CC_VS:   r = f.v;
      CC_VC:   r = !f.v;
      CC_HI:   r = f.c && !f.z;
      CC_LS:   r = !f.c || f.z;
      CC_GE:   r = (f.n == f.v);
      CC_LT:   r = (f.n != f.v);
      CC_GT:   r = !f.z && (f.n == f.v);
      CC_LE:   r = f.z || (f.n != f.v);
      CC_NV:   r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_v2_if.sv
// Instruction fetch and data load/store bus between cpu_v2 and its memories.
interface cpu_v2_if #(
  parameter int DWIDTH     = 16,
  parameter int IADDRWIDTH = 16,
  parameter int DADDRWIDTH = 16
);
  // Handshake: re/we are requests held with stable address/data until the
  // edge where rvalid/wready is high; rvalid/wready seen without the
  // matching request are ignored. idata answers iaddr one cycle later.
  logic [IADDRWIDTH-1:0] iaddr;
  logic [15:0]           idata;
  logic [DADDRWIDTH-1:0] raddr;
  logic                  re;
  logic [DWIDTH-1:0]     rdata;
  logic                  rvalid;
  logic [DADDRWIDTH-1:0] waddr;
  logic [DWIDTH-1:0]     wdata;
  logic                  we;
  logic                  wready;

  modport master (
    output iaddr, raddr, re, waddr, wdata, we,
    input  idata, rdata, rvalid, wready
  );

  modport slave (
    input  iaddr, raddr, re, waddr, wdata, we,
    output idata, rdata, rvalid, wready
  );
endinterface

// File: rtl/cpu_v2_alu.sv
// Combinational ALU; result wraps modulo 2^DWIDTH, flags from the result.
module cpu_v2_alu
  import cpu_v2_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic [3:0]        op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              cin,
  output logic [DWIDTH-1:0] result,
  output flags_t            flags
);
  logic [DWIDTH-1:0] bx;
  logic              cx;
  logic [DWIDTH:0]   sum;
  logic              arith;

  always_comb begin
    arith  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
    // subtract is a + ~b + 1, so C means "no borrow"
    bx     = (op == OP_SUB) ? ~b : b;
    cx     = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? cin : 1'b0);
    sum    = {1'b0, a} + {1'b0, bx} + {{DWIDTH{1'b0}}, cx};
    case (op)
      OP_ADD, OP_SUB, OP_ADC: result = sum[DWIDTH-1:0];
      OP_AND:                 result = a & b;
      OP_OR:                  result = a | b;
      OP_XOR:                 result = a ^ b;
      OP_MOV:                 result = b;
      default:                result = a;
    endcase
    flags.n = result[DWIDTH-1];
    flags.z = (result == '0);
    flags.c = arith ? sum[DWIDTH] : 1'b0;
    flags.v = arith ? ((a[DWIDTH-1] == bx[DWIDTH-1]) && (result[DWIDTH-1] != a[DWIDTH-1])) : 1'b0;
  end
endmodule

// File: rtl/cpu_v2_regfile.sv
// Eight-entry register file, three read ports, one write port, no reset.
module cpu_v2_regfile #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [2:0]        a_addr,
  output logic [DWIDTH-1:0] a_data,
  input  logic [2:0]        b_addr,
  output logic [DWIDTH-1:0] b_data,
  input  logic [2:0]        d_addr,
  output logic [DWIDTH-1:0] d_data
);
  logic [DWIDTH-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
  end

  assign a_data = regs[a_addr];
  assign b_data = regs[b_addr];
  assign d_data = regs[d_addr];
endmodule

// File: rtl/cpu_v2.sv
// Two-stage core: S1 fetch (pc, iaddr = pc_next), S2 decode/execute (ir)
// with a DECODE/IMM/LOAD/STORE sequencer for multi-cycle instructions.
module cpu_v2
  import cpu_v2_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int IADDRWIDTH = 16,
  parameter int DADDRWIDTH = 16,
  parameter int NREGS      = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  cpu_v2_if.master bus,
  output state_t   dbg_state
);
  if (NREGS != 8) begin : g_bad_nregs
    $error("cpu_v2: NREGS must be 8");
  end
  if (DWIDTH < 16 || DWIDTH > 32) begin : g_bad_dwidth
    $error("cpu_v2: DWIDTH must be 16..32");
  end

  state_t                state, state_nxt;
  flags_t                flags, alu_flags;
  logic [IADDRWIDTH-1:0] pc, pc_next, pc_plus1, br_target, target;
  logic [15:0]           ir, imm_q;
  logic [DWIDTH-1:0]     ld_q, a_data, b_data, d_data, op_b, alu_res;
  logic                  boot, done, exec, redirect, imm_adv, ld_cap;
  logic                  rf_we, flags_we, re_c, we_c;

  logic [3:0] op;
  logic       d_ind;
  logic [2:0] rd, ra, rb;
  logic [1:0] bmode;
  logic       is_branch, is_alu, need_imm, need_load, is_store, is_jump;

  assign op        = ir[15:12];
  assign d_ind     = ir[11];
  assign rd        = ir[10:8];
  assign ra        = ir[7:5];
  assign bmode     = ir[4:3];
  assign rb        = ir[2:0];
  assign is_branch = (op[3:2] == 2'b10);
  assign is_alu    = !op[3] && (op != OP_NOP);
  assign need_imm  = is_alu && (bmode == BM_REG) && (rb == 3'd0);
  assign need_load = is_alu && (bmode == BM_MEM) && (rb != 3'd0);
  assign is_store  = is_alu && d_ind && (rd != 3'd0);
  assign is_jump   = is_alu && d_ind && (rd == 3'd0);

  // pc holds the address of the word currently on idata (the delay slot)
  assign pc_plus1  = pc + IADDRWIDTH'(1);
  assign br_target = pc + IADDRWIDTH'($signed(ir[9:0]));

  cpu_v2_regfile #(.DWIDTH(DWIDTH)) u_regfile (
    .clk    (clk),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (alu_res),
    .a_addr (ra),
    .a_data (a_data),
    .b_addr (rb),
    .b_data (b_data),
    .d_addr (rd),
    .d_data (d_data)
  );

  always_comb begin
    case (bmode)
      BM_REG:  op_b = (rb == 3'd0) ? DWIDTH'($signed(imm_q)) : b_data;
      BM_MEM:  op_b = (rb == 3'd0) ? DWIDTH'(pc_plus1)
                    : ((state == S_LOAD) ? bus.rdata : ld_q);
      default: op_b = DWIDTH'($signed(ir[3:0]));
    endcase
  end

  cpu_v2_alu #(.DWIDTH(DWIDTH)) u_alu (
    .op     (op),
    .a      (a_data),
    .b      (op_b),
    .cin    (flags.c),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    exec      = 1'b0;
    redirect  = 1'b0;
    target    = br_target;
    imm_adv   = 1'b0;
    ld_cap    = 1'b0;
    re_c      = 1'b0;
    we_c      = 1'b0;
    rf_we     = 1'b0;
    flags_we  = 1'b0;
    case (state)
      S_DECODE, S_IMM: begin
        if (state == S_DECODE && is_branch) begin
          done     = 1'b1;
          redirect = cond_met(ir[13:10], flags);
        end else if (state == S_DECODE && !is_alu) begin
          done = 1'b1;
        end else if (state == S_DECODE && need_imm) begin
          imm_adv   = 1'b1;
          state_nxt = S_IMM;
        end else if (state == S_DECODE && need_load) begin
          state_nxt = S_LOAD;
        end else if (is_store) begin
          we_c      = 1'b1;
          exec      = bus.wready;
          state_nxt = bus.wready ? S_DECODE : S_STORE;
        end else begin
          exec      = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_LOAD: begin
        re_c = 1'b1;
        if (bus.rvalid) begin
          ld_cap    = 1'b1;
          exec      = !is_store;
          state_nxt = is_store ? S_STORE : S_DECODE;
        end
      end
      default: begin
        we_c = 1'b1;
        if (bus.wready) begin
          exec      = 1'b1;
          state_nxt = S_DECODE;
        end
      end
    endcase
    if (exec) begin
      done     = 1'b1;
      rf_we    = !d_ind;
      flags_we = !is_jump;
      if (is_jump) begin
        redirect = 1'b1;
        target   = IADDRWIDTH'(alu_res);
      end
    end
    if (redirect)              pc_next = target;
    else if (done || imm_adv)  pc_next = pc_plus1;
    else                       pc_next = pc;
  end

  // boot squashes the first fetched word, which answers the reset-time iaddr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '1;
      ir    <= NOP_INSN;
      state <= S_DECODE;
      flags <= '0;
      boot  <= 1'b1;
      imm_q <= '0;
      ld_q  <= '0;
    end else begin
      boot  <= 1'b0;
      state <= state_nxt;
      pc    <= pc_next;
      if (done)     ir    <= (redirect || boot) ? NOP_INSN : bus.idata;
      if (imm_adv)  imm_q <= bus.idata;
      if (ld_cap)   ld_q  <= bus.rdata;
      if (flags_we) flags <= alu_flags;
    end
  end

  assign bus.iaddr = pc_next;
  assign bus.raddr = DADDRWIDTH'(b_data);
  assign bus.re    = re_c;
  assign bus.waddr = DADDRWIDTH'(d_data);
  assign bus.wdata = alu_res;
  assign bus.we    = we_c;
  assign dbg_state = state;
endmodule

// File: tb/tb_cpu_v2.sv
// Directed bench for cpu_v2 at DWIDTH=32: ALU, load/store handshakes,
// conditional branch with delay slot, and reset during a load.
module tb_cpu_v2;
  import cpu_v2_pkg::*;

  localparam int DW = 32;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_fail = 0;
  logic [15:0] imem [0:255];

  cpu_v2_if #(.DWIDTH(DW), .IADDRWIDTH(16), .DADDRWIDTH(16)) bus ();

  cpu_v2 #(.DWIDTH(DW), .IADDRWIDTH(16), .DADDRWIDTH(16), .NREGS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset / instruction memory
  always #5 clk = ~clk;

  always @(posedge clk) bus.idata <= imem[bus.iaddr[7:0]];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = NOP_INSN;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rvalid = 1'b0;
    bus.wready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: answers a load delay cycles after re first rises
  task automatic serve_load(input int delay, input logic [15:0] exp_raddr,
                            input logic [15:0] exp_iaddr, input logic [31:0] data,
                            output int re_cycles);
    re_cycles = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (bus.re) begin
        re_cycles++;
        check("raddr", 32'(bus.raddr), 32'(exp_raddr));
        check("load_iaddr_hold", 32'(bus.iaddr), 32'(exp_iaddr));
        check("no_we_during_re", 32'(bus.we), 32'd0);
        if (re_cycles == delay + 1) begin
          bus.rvalid = 1'b1;
          bus.rdata  = data;
        end
      end else begin
        bus.rvalid = 1'b0;
        if (re_cycles > 0) break;
      end
    end
    bus.rvalid = 1'b0;
  endtask

  // driver: raises wready delay cycles after we first rises
  task automatic serve_store(input int delay, input logic [15:0] exp_waddr,
                             input logic [31:0] exp_wdata, input logic [15:0] exp_iaddr,
                             output int we_cycles);
    we_cycles = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (bus.we) begin
        we_cycles++;
        check("waddr", 32'(bus.waddr), 32'(exp_waddr));
        check("wdata", bus.wdata, exp_wdata);
        check("store_iaddr_hold", 32'(bus.iaddr), 32'(exp_iaddr));
        check("no_re_during_we", 32'(bus.re), 32'd0);
        bus.wready = (we_cycles == delay + 1);
      end else begin
        bus.wready = 1'b0;
        if (we_cycles > 0) break;
      end
    end
    bus.wready = 1'b0;
  endtask

  int  cnt;
  logic got_re;

  initial begin
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.wready = 1'b0;
    clear_imem();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_re", 32'(bus.re), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_iaddr", 32'(bus.iaddr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_DECODE));
    check("rst_flags", 32'(dut.flags), 32'd0);

    // add r1 = r0 + (-1) at 32 bits
    clear_imem();
    imem[0] = 16'h6000;   // mov r0, #0
    imem[1] = 16'h110F;   // add r1, r0, #-1
    do_reset();
    repeat (8) @(negedge clk);
    check("add_r1", dut.u_regfile.regs[1], 32'hFFFF_FFFF);
    check("add_n", 32'(dut.flags.n), 32'd1);
    check("add_z", 32'(dut.flags.z), 32'd0);
    check("add_c", 32'(dut.flags.c), 32'd0);
    check("add_v", 32'(dut.flags.v), 32'd0);

    // load with rvalid three cycles late
    clear_imem();
    imem[0] = 16'h6305;   // mov r3, #5
    imem[1] = 16'h641B;   // mov r4, [r3]
    do_reset();
    serve_load(3, 16'd5, 16'd2, 32'h1234, cnt);
    check("load_re_cycles", 32'(cnt), 32'd4);
    repeat (2) @(negedge clk);
    check("load_r4", dut.u_regfile.regs[4], 32'h1234);
    check("load_r3_kept", dut.u_regfile.regs[3], 32'd5);

    // store via next-word immediate address, wready two cycles late
    clear_imem();
    imem[0] = 16'h6210;   // mov r2, #imm16
    imem[1] = 16'h0040;
    imem[2] = 16'h6507;   // mov r5, #7
    imem[3] = 16'h1AA3;   // add [r2], r5, #3
    do_reset();
    serve_store(2, 16'h0040, 32'h0000_000A, 16'd4, cnt);
    check("store_we_cycles", 32'(cnt), 32'd3);
    repeat (2) @(negedge clk);
    check("store_r2_kept", dut.u_regfile.regs[2], 32'h40);
    check("store_r5_kept", dut.u_regfile.regs[5], 32'd7);

    // bhi taken (C=1,Z=0) then not taken (C=1,Z=1)
    clear_imem();
    imem[0] = 16'h6100;   // mov r1, #0
    imem[1] = 16'h6605;   // mov r6, #5
    imem[2] = 16'h27C1;   // sub r7, r6, #1
    imem[3] = 16'hA002;   // bhi +2 -> 6
    imem[4] = 16'h6101;   // delay slot, squashed
    imem[5] = 16'h6102;   // skipped
    imem[6] = 16'h27D6;   // sub r7, r6, r6
    imem[7] = 16'hA002;   // bhi +2, not taken
    imem[8] = 16'h6303;   // mov r3, #3
    imem[9] = 16'h6404;   // mov r4, #4
    do_reset();
    repeat (20) @(negedge clk);
    check("bhi_slot_nop", dut.u_regfile.regs[1], 32'd0);
    check("bhi_r7", dut.u_regfile.regs[7], 32'd0);
    check("bhi_nt_slot", dut.u_regfile.regs[3], 32'd3);
    check("bhi_nt_fall", dut.u_regfile.regs[4], 32'd4);

    // reset asserted mid-load
    clear_imem();
    imem[0] = 16'h6305;
    imem[1] = 16'h641B;
    do_reset();
    got_re = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.re) begin
        got_re = 1'b1;
        break;
      end
    end
    check("mid_load_re_seen", 32'(got_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_load_rst_re", 32'(bus.re), 32'd0);
    check("mid_load_rst_state", 32'(dbg_state), 32'(S_DECODE));
    check("mid_load_rst_iaddr", 32'(bus.iaddr), 32'd0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0BAD;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_iaddr0", 32'(bus.iaddr), 32'd0);
    @(negedge clk);
    check("post_rst_iaddr1", 32'(bus.iaddr), 32'd1);
    check("late_rvalid_ignored", 32'(bus.re), 32'd0);
    bus.rvalid = 1'b0;
    serve_load(0, 16'd5, 16'd2, 32'h4321, cnt);
    check("reload_re_cycles", 32'(cnt), 32'd1);
    repeat (2) @(negedge clk);
    check("reload_r4", dut.u_regfile.regs[4], 32'h4321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
